cmp_arbiter: RTL and testbench

- Shares one 32-bit comparator (signed-less, unsigned-less, equal) between two requesters: port 0 = branch unit, port 1 = SLT/SLTU unit.
- Per-port valid/ready request channel and per-port valid/ready response channel.
- Round-robin arbitration; result registered, one cycle latency.
- Sits in EX stage beside the ALU; decodes RV32I funct3 into a single condition bit.

---
 rtl/cmp_arbiter_if.sv | 26 ++
 rtl/cmp_arbiter.sv | 132 +++++++++++++
 tb/tb_cmp_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmp_arbiter_if.sv
// Request/response channel bundle for cmp_arbiter: two requesters share one comparator.
interface cmp_arbiter_if #(
  parameter int unsigned W = 32
);
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [2:0]   req0_op;
  logic [2:0]   req1_op;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic         rsp_result;

  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req0_a, req0_b, req1_a, req1_b, req0_op, req1_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/cmp_arbiter.sv
// Round-robin shared 32-bit comparator (branch unit on port 0, SLT/SLTU on port 1), 1-cycle result.
// Optional CMP_ARB_STATS_EN adds saturating grant/stall counters.
module cmp_arbiter #(
  parameter int unsigned W       = 32,
  parameter int unsigned RR_INIT = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  cmp_arbiter_if.slave   bus
`ifdef CMP_ARB_STATS_EN
  ,
  output logic [15:0]    grant0_cnt,
  output logic [15:0]    grant1_cnt,
  output logic [15:0]    stall_cnt
`endif
);

  typedef enum logic {S_IDLE, S_RESP} state_t;

  state_t       r_state;
  state_t       w_next;
  logic         r_owner;
  logic         r_result;
  logic         r_ptr;

  logic         w_owner_rdy;
  logic         w_allow;
  logic         w_pick;
  logic         w_accept;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [2:0]   w_op;
  logic [W:0]   w_sum;
  logic         w_ul;
  logic         w_sl;
  logic         w_ovf;
  logic         w_eq;
  logic         w_cond;
  logic [1:0]   w_req_ready;

  // Flush suppresses any grant, so a redirect never accepts a new compare.
  assign w_owner_rdy = bus.rsp_ready[r_owner];
  assign w_allow     = !flush && ((r_state == S_IDLE) || w_owner_rdy);
  assign w_pick      = (&bus.req_valid) ? r_ptr : bus.req_valid[1];
  assign w_accept    = w_allow && (|bus.req_valid);

  assign w_a  = w_pick ? bus.req1_a  : bus.req0_a;
  assign w_b  = w_pick ? bus.req1_b  : bus.req0_b;
  assign w_op = w_pick ? bus.req1_op : bus.req0_op;

  always_comb begin
    w_sum  = {1'b0, w_a} + {1'b0, ~w_b} + (W+1)'(1);
    w_ul   = ~w_sum[W];
    w_ovf  = (w_a[W-1] ^ w_b[W-1]) & (w_sum[W-1] ^ w_a[W-1]);
    w_sl   = w_sum[W-1] ^ w_ovf;
    w_eq   = (w_sum[W-1:0] == '0);
    w_cond = 1'b0;
    case (w_op)
      3'b000:          w_cond = w_eq;
      3'b001:          w_cond = ~w_eq;
      3'b100, 3'b010:  w_cond = w_sl;
      3'b101:          w_cond = ~w_sl;
      3'b110, 3'b011:  w_cond = w_ul;
      3'b111:          w_cond = ~w_ul;
      default:         w_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush)                                  w_next = S_IDLE;
    else if (w_accept)                          w_next = S_RESP;
    else if ((r_state == S_RESP) && w_owner_rdy) w_next = S_IDLE;
  end

  always_comb begin
    w_req_ready    = '0;
    bus.rsp_valid  = '0;
    bus.rsp_result = 1'b0;
    if (w_accept) w_req_ready = w_pick ? 2'b10 : 2'b01;
    if (r_state == S_RESP) begin
      bus.rsp_valid  = r_owner ? 2'b10 : 2'b01;
      bus.rsp_result = r_result;
    end
  end

  assign bus.req_ready = w_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= 1'b0;
      r_result <= 1'b0;
      r_ptr    <= 1'(RR_INIT);
    end else if (w_accept) begin
      r_owner  <= w_pick;
      r_result <= w_cond;
      r_ptr    <= ~w_pick;
    end
  end

`ifdef CMP_ARB_STATS_EN
  logic [15:0] r_g0_cnt;
  logic [15:0] r_g1_cnt;
  logic [15:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = |(bus.req_valid & ~w_req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_g0_cnt    <= '0;
      r_g1_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_accept && !w_pick && (r_g0_cnt != '1))  r_g0_cnt    <= r_g0_cnt + 16'd1;
      if (w_accept &&  w_pick && (r_g1_cnt != '1))  r_g1_cnt    <= r_g1_cnt + 16'd1;
      if (w_stall && (r_stall_cnt != '1))          r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign grant0_cnt = r_g0_cnt;
  assign grant1_cnt = r_g1_cnt;
  assign stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter: stimulus pushes expected responses, a monitor pops on handshake.
module tb_cmp_arbiter;

  logic clk;
  logic rst_n;
  logic flush;

  cmp_arbiter_if #(.W(32)) bus ();

`ifdef CMP_ARB_STATS_EN
  logic [15:0] g0_cnt;
  logic [15:0] g1_cnt;
  logic [15:0] st_cnt;
`endif

  cmp_arbiter #(.W(32), .RR_INIT(0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
`ifdef CMP_ARB_STATS_EN
    ,
    .grant0_cnt (g0_cnt),
    .grant1_cnt (g1_cnt),
    .stall_cnt  (st_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic port;
    logic res;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        r;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv0(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req0_op = op;
    bus.req0_a  = a;
    bus.req0_b  = b;
  endtask

  task automatic drv1(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.req1_op = op;
    bus.req1_a  = a;
    bus.req1_b  = b;
  endtask

  task automatic push(input logic port, input logic res);
    exp_t e;
    e.port = port;
    e.res  = res;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("reset_rsp_result", 32'(bus.rsp_result), 32'h0);
    rst_n = 1'b1;
    tick();
  endtask

  // Monitor: compares every consumed response against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && !flush && ((bus.rsp_valid & bus.rsp_ready) != 2'b00)) begin
      if (exp_q.size() == 0) begin
        chk("mon_unexpected_rsp", 32'(bus.rsp_valid), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_rsp_valid", 32'(bus.rsp_valid), e.port ? 32'h2 : 32'h1);
        chk("mon_rsp_result", 32'(bus.rsp_result), 32'(e.res));
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  localparam vec_t VT [12] = '{
    '{3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0},
    '{3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1},
    '{3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1},
    '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0},
    '{3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0},
    '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1},
    '{3'b010, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0},
    '{3'b011, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1},
    '{3'b000, 32'h8000_0000, 32'h8000_0000, 1'b1},
    '{3'b101, 32'h0000_0000, 32'h0000_0000, 1'b1},
    '{3'b110, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1},
    '{3'b000, 32'h0000_0000, 32'h0000_0001, 1'b0}
  };

  initial begin
    bus.req0_op = 3'b000; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_op = 3'b000; bus.req1_a = '0; bus.req1_b = '0;
    do_reset();

    // BLT then BLTU on port 0, back to back
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b01;
    drv0(3'b100, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk);
    chk("blt_req_ready", 32'(bus.req_ready), 32'h1);
    push(1'b0, 1'b1);
    tick();
    drv0(3'b110, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk);
    chk("bltu_req_ready", 32'(bus.req_ready), 32'h1);
    push(1'b0, 1'b0);
    tick();
    bus.req_valid = 2'b00;
    tick();

    // Both ports contend: grants alternate 0,1,0,1
    do_reset();
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b11;
    drv0(3'b000, 32'd5, 32'd5);
    drv1(3'b011, 32'd3, 32'd7);
    for (int unsigned i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_req_ready", 32'(bus.req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      push(i[0], 1'b1);
      tick();
    end
    bus.req_valid = 2'b00;
    tick();

    // Port 1 SLT held by backpressure; port 0 waits then gets same-cycle grant
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b01;
    drv1(3'b010, 32'h8000_0000, 32'h7FFF_FFFF);
    @(negedge clk);
    chk("hold_accept", 32'(bus.req_ready), 32'h2);
    push(1'b1, 1'b1);
    tick();
    bus.req_valid = 2'b11;
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'h2);
      chk("hold_rsp_result", 32'(bus.rsp_result), 32'h1);
      chk("hold_req_ready", 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.rsp_ready = 2'b11;
    @(negedge clk);
    chk("release_grant", 32'(bus.req_ready), 32'h1);
    push(1'b0, 1'b1);
    tick();
    bus.req_valid = 2'b00;
    tick();

    // Flush drops pending response and blocks the grant in that cycle
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    drv0(3'b000, 32'd5, 32'd6);
    @(negedge clk);
    chk("flush_setup_accept", 32'(bus.req_ready), 32'h1);
    tick();
    flush         = 1'b1;
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b10;
    drv1(3'b011, 32'd3, 32'd7);
    @(negedge clk);
    chk("flush_req_ready", 32'(bus.req_ready), 32'h0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("post_flush_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("post_flush_accept", 32'(bus.req_ready), 32'h2);
    push(1'b1, 1'b1);
    tick();
    bus.req_valid = 2'b00;
    tick();

    // Condition decode table on port 0
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b01;
    foreach (VT[i]) begin
      drv0(VT[i].op, VT[i].a, VT[i].b);
      @(negedge clk);
      chk("vec_req_ready", 32'(bus.req_ready), 32'h1);
      push(1'b0, VT[i].r);
      tick();
    end
    bus.req_valid = 2'b00;
    tick();

    // Async reset mid-RESP; pointer returns to RR_INIT
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    drv0(3'b000, 32'd7, 32'd7);
    @(negedge clk);
    chk("areset_setup_accept", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    #1;
    chk("areset_pre_valid", 32'(bus.rsp_valid), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("areset_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("areset_rsp_result", 32'(bus.rsp_result), 32'h0);
    rst_n = 1'b1;
    tick();
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b11;
    drv0(3'b101, 32'hFFFF_FFFF, 32'h1);
    drv1(3'b111, 32'hFFFF_FFFF, 32'h1);
    @(negedge clk);
    chk("areset_first_grant", 32'(bus.req_ready), 32'h1);
    push(1'b0, 1'b0);
    tick();
    @(negedge clk);
    chk("areset_second_grant", 32'(bus.req_ready), 32'h2);
    push(1'b1, 1'b1);
    tick();
    bus.req_valid = 2'b00;
    tick();

`ifdef CMP_ARB_STATS_EN
    do_reset();
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b00;
    drv0(3'b000, 32'd5, 32'd5);
    tick();
    bus.req_valid = 2'b11;
    repeat (3) tick();
    bus.req_valid = 2'b00;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("stats_g0_small", 32'(g0_cnt), 32'd1);
    chk("stats_g1_small", 32'(g1_cnt), 32'd0);
    chk("stats_stall", 32'(st_cnt), 32'd3);
    tick();
    bus.rsp_ready = 2'b11;
    bus.req_valid = 2'b01;
    for (int unsigned i = 0; i < 70000; i++) begin
      push(1'b0, 1'b1);
      tick();
    end
    bus.req_valid = 2'b00;
    tick();
    @(negedge clk);
    chk("stats_g0_sat", 32'(g0_cnt), 32'h0000_FFFF);
    chk("stats_g1_zero", 32'(g1_cnt), 32'h0);
    tick();
`endif

    for (int unsigned i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
